// File: rtl/inst_loader.sv
// inst_loader: streams host words over valid/ready into a writable instruction store read combinationally by fetch.
// Define INST_LOADER_CHECKSUM_EN to build the running XOR checksum of accepted words; otherwise Checksum is tied to 0.
module inst_loader #(
    parameter int IW = 16,
    parameter int DW = 9
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    input  logic [IW:0]   Length,
    input  logic [DW-1:0] WordIn,
    input  logic          WordValid,
    output logic          WordReady,
    input  logic [IW-1:0] InstAddress,
    output logic [DW-1:0] InstOut,
    output logic          Busy,
    output logic          Done,
    output logic [IW:0]   WordCount,
    output logic [DW-1:0] Checksum
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW:0] LAST = {{IW{1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW:0]   remaining;
    logic [IW:0]   count;
    logic          accept;
    logic          startok;

    logic [DW-1:0] mem [0:(2**IW)-1];

    assign accept  = (state == LOAD) && WordValid;
    assign startok = Start && ((state == IDLE) || (state == DONE));

    assign WordReady = (state == LOAD);
    assign Busy      = (state == LOAD);
    assign Done      = (state == DONE);
    assign WordCount = count;

    // Combinational fetch port; a same-cycle write shows up only after its edge.
    assign InstOut = mem[InstAddress];

    // The store has no reset so a program survives a loader reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            mem[ptr] <= WordIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        ptr       <= StartAddr;
                        remaining <= Length;
                        count     <= '0;
                        state     <= (Length == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (WordValid) begin
                        ptr       <= ptr + 1'b1;
                        count     <= count + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            csum <= '0;
        end else if (startok) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ WordIn;
        end
    end

    assign Checksum = csum;
`else
    logic unusedStart;
    assign unusedStart = startok;
    assign Checksum    = '0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scoreboard bench for inst_loader; stimulus queues expectations, a negedge monitor pops and compares.
// Checksum expectations follow INST_LOADER_CHECKSUM_EN.
module tb_inst_loader;

    localparam int IW = 4;
    localparam int DW = 9;

    localparam int SEL_READY    = 0;
    localparam int SEL_BUSY     = 1;
    localparam int SEL_DONE     = 2;
    localparam int SEL_COUNT    = 3;
    localparam int SEL_CSUM     = 4;
    localparam int SEL_MEM      = 5;
    localparam int SEL_BUSYCYC  = 6;
    localparam int SEL_READYCYC = 7;
    localparam int SEL_NOTREADY = 8;
    localparam int SEL_QEMPTY   = 9;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [IW-1:0] StartAddr;
    logic [IW:0]   Length;
    logic [DW-1:0] WordIn;
    logic          WordValid;
    logic          WordReady;
    logic [IW-1:0] InstAddress;
    logic [DW-1:0] InstOut;
    logic          Busy;
    logic          Done;
    logic [IW:0]   WordCount;
    logic [DW-1:0] Checksum;

    typedef struct {
        string name;
        int    sel;
        int    base;
        int    exp;
    } check_t;

    typedef struct {
        int count;
        int csum;
    } done_t;

    check_t checkQ[$];
    done_t  doneQ[$];
    int     acceptQ[$];

    int   compared       = 0;
    int   mismatched     = 0;
    int   busyCycles     = 0;
    int   readyCycles    = 0;
    int   notReadyInLoad = 0;
    logic prevDone       = 1'b0;

    inst_loader #(.IW(IW), .DW(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Length     (Length),
        .WordIn     (WordIn),
        .WordValid  (WordValid),
        .WordReady  (WordReady),
        .InstAddress(InstAddress),
        .InstOut    (InstOut),
        .Busy       (Busy),
        .Done       (Done),
        .WordCount  (WordCount),
        .Checksum   (Checksum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int cs(int v);
`ifdef INST_LOADER_CHECKSUM_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int actualOf(int sel);
        case (sel)
            SEL_READY:    return int'(WordReady);
            SEL_BUSY:     return int'(Busy);
            SEL_DONE:     return int'(Done);
            SEL_COUNT:    return int'(WordCount);
            SEL_CSUM:     return int'(Checksum);
            SEL_MEM:      return int'(InstOut);
            SEL_BUSYCYC:  return busyCycles;
            SEL_READYCYC: return readyCycles;
            SEL_NOTREADY: return notReadyInLoad;
            SEL_QEMPTY:   return doneQ.size() + acceptQ.size();
            default:      return -1;
        endcase
    endfunction

    // Monitor: samples on the falling edge, away from the edge where the DUT updates.
    always @(negedge Clk) begin
        int     e;
        int     act;
        done_t  d;
        check_t c;
        if (Busy === 1'b1) busyCycles++;
        if (WordReady === 1'b1) readyCycles++;
        if (Busy === 1'b1 && WordReady !== 1'b1) notReadyInLoad++;
        if (WordValid === 1'b1 && WordReady === 1'b1 && Reset === 1'b0) begin
            compared++;
            if (acceptQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL accept_unexpected: got accept of 0x%0h at WordCount=%0d, required no accept", WordIn, WordCount);
            end else begin
                e = acceptQ.pop_front();
                if (int'(WordCount) != e) begin
                    mismatched++;
                    $display("[TB] FAIL accept_count: got WordCount=%0d, required %0d", WordCount, e);
                end
            end
        end
        if (Done === 1'b1 && prevDone !== 1'b1) begin
            if (doneQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL done_unexpected: got Done=1, required no completion");
            end else begin
                d = doneQ.pop_front();
                compared += 2;
                if (int'(WordCount) != d.count) begin
                    mismatched++;
                    $display("[TB] FAIL done_count: got %0d, required %0d", WordCount, d.count);
                end
                if (int'(Checksum) != d.csum) begin
                    mismatched++;
                    $display("[TB] FAIL done_checksum: got 0x%0h, required 0x%0h", Checksum, d.csum);
                end
            end
        end
        prevDone = Done;
        while (checkQ.size() > 0) begin
            c   = checkQ.pop_front();
            act = actualOf(c.sel) - c.base;
            compared++;
            if (act != c.exp) begin
                mismatched++;
                $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(string name, int sel, int exp, int base = 0);
        check_t c;
        c.name = name;
        c.sel  = sel;
        c.base = base;
        c.exp  = exp;
        checkQ.push_back(c);
        @(negedge Clk);
        #1;
    endtask

    task automatic checkMem(int a, int exp);
        InstAddress = a[IW-1:0];
        checkOutput($sformatf("mem[%0d]", a), SEL_MEM, exp);
    endtask

    task automatic applyReset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic applyStimulus(int addr, int len, bit expectDone, int expCount, int expCsum);
        done_t d;
        if (expectDone) begin
            d.count = expCount;
            d.csum  = expCsum;
            doneQ.push_back(d);
        end
        Start     = 1'b1;
        StartAddr = addr[IW-1:0];
        Length    = len[IW:0];
        tick();
        Start = 1'b0;
    endtask

    task automatic sendWord(int data, int gap, int expCount);
        acceptQ.push_back(expCount);
        WordIn    = data[DW-1:0];
        WordValid = 1'b1;
        tick();
        WordValid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic waitDone(int budget);
        int n = 0;
        while (Done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (Done !== 1'b1) checkOutput("done_timeout", SEL_DONE, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        Reset       = 1'b1;
        Start       = 1'b0;
        StartAddr   = '0;
        Length      = '0;
        WordIn      = '0;
        WordValid   = 1'b0;
        InstAddress = '0;
        tick();
        Reset = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_ready", SEL_READY, 0);
        checkOutput("rst_busy", SEL_BUSY, 0);
        checkOutput("rst_done", SEL_DONE, 0);
        checkOutput("rst_count", SEL_COUNT, 0);
        checkOutput("rst_csum", SEL_CSUM, 0);

        $display("[TB] full-store fill with known pattern");
        applyStimulus(0, 16, 1'b1, 16, cs(0));
        for (int i = 0; i < 16; i++) sendWord(9'h040 + i, 0, i);
        waitDone(4);
        checkMem(5, 9'h045);

        $display("[TB] basic load");
        applyReset();
        base = busyCycles;
        applyStimulus(0, 3, 1'b1, 3, cs(9'h05A));
        sendWord(9'h1A5, 0, 0);
        sendWord(9'h0FF, 0, 1);
        sendWord(9'h100, 0, 2);
        waitDone(4);
        checkOutput("busy_cycles", SEL_BUSYCYC, 3, base);
        checkOutput("basic_count", SEL_COUNT, 3);
        checkMem(0, 9'h1A5);
        checkMem(1, 9'h0FF);
        checkMem(2, 9'h100);
        checkMem(3, 9'h043);

        $display("[TB] backpressure");
        applyReset();
        base = notReadyInLoad;
        applyStimulus(4, 2, 1'b1, 2, cs(9'h1FF));
        sendWord(9'h0AA, 4, 0);
        sendWord(9'h155, 0, 1);
        checkOutput("bp_done_after_2nd", SEL_DONE, 1);
        checkOutput("bp_ready_held", SEL_NOTREADY, 0, base);
        checkMem(4, 9'h0AA);
        checkMem(5, 9'h155);
        checkMem(6, 9'h046);

        $display("[TB] address wrap");
        applyReset();
        applyStimulus(14, 4, 1'b1, 4, cs(9'h004));
        for (int i = 0; i < 4; i++) sendWord(i + 1, 0, i);
        waitDone(4);
        checkMem(14, 1);
        checkMem(15, 2);
        checkMem(0, 3);
        checkMem(1, 4);
        checkMem(2, 9'h100);

        $display("[TB] zero length");
        applyReset();
        base = readyCycles;
        applyStimulus(7, 0, 1'b1, 0, cs(0));
        checkOutput("len0_done", SEL_DONE, 1);
        checkOutput("len0_ready_cycles", SEL_READYCYC, 0, base);
        checkOutput("len0_count", SEL_COUNT, 0);
        checkMem(7, 9'h047);

        $display("[TB] reset mid-load");
        applyReset();
        applyStimulus(8, 5, 1'b0, 0, 0);
        sendWord(9'h111, 0, 0);
        sendWord(9'h122, 0, 1);
        #2;
        Reset = 1'b1;
        checkOutput("midrst_busy", SEL_BUSY, 0);
        checkOutput("midrst_ready", SEL_READY, 0);
        checkOutput("midrst_done", SEL_DONE, 0);
        checkOutput("midrst_count", SEL_COUNT, 0);
        checkOutput("midrst_csum", SEL_CSUM, 0);
        Reset = 1'b0;
        tick();
        checkMem(8, 9'h111);
        checkMem(9, 9'h122);
        checkMem(10, 9'h04A);
        checkMem(12, 9'h04C);

        $display("[TB] start ignored during load");
        applyReset();
        applyStimulus(0, 3, 1'b1, 3, cs(9'h1C0));
        sendWord(9'h1C1, 0, 0);
        Start     = 1'b1;
        StartAddr = 4'd8;
        Length    = 5'd1;
        sendWord(9'h1C2, 0, 1);
        Start = 1'b0;
        sendWord(9'h1C3, 0, 2);
        waitDone(4);
        checkOutput("ign_count", SEL_COUNT, 3);
        checkMem(0, 9'h1C1);
        checkMem(1, 9'h1C2);
        checkMem(2, 9'h1C3);
        checkMem(8, 9'h111);

        checkOutput("queues_drained", SEL_QEMPTY, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side counterpart of the instruction memory: accepts a stream of 9-bit machine-code words over a valid/ready handshake and stores them into a writable instruction store.
- The same store is read combinationally by the fetch stage, with the read port behaving like the instruction ROM.
- Lets the testbench or host load a program at run time instead of only at elaboration, and holds the CPU in reset while loading.

Parameters:
- IW, 16, instruction address width; the store holds 2**IW words.
- DW, 9, instruction word width.

Ports:
- Clk  input  1  single clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- StartAddr  input  IW  first write address; latched on accepted Start.
- Length  input  IW+1  number of words to load, 0..2**IW; latched on accepted Start.
- WordIn  input  DW  instruction word from the host.
- WordValid  input  1  WordIn is valid.
- WordReady  output  1  loader can accept a word this cycle.
- InstAddress  input  IW  fetch read address.
- InstOut  output  DW  combinational read data, Mem[InstAddress].
- Busy  output  1  high in LOAD; the CPU's reset is ORed with Busy.
- Done  output  1  high in DONE; cleared by the next accepted Start or by Reset.
- WordCount  output  IW+1  number of words accepted in the current or last load.
- Checksum  output  DW  running XOR of accepted words; see Optional Feature.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - WordReady=0, Busy=0, Done=0, WordCount=0, Checksum=0, write pointer=0.
  - Memory contents are NOT cleared.
  - InstOut continues to reflect Mem[InstAddress].
- States: IDLE, LOAD, DONE.
- IDLE/DONE with Start=1 at a rising edge:
  - Latch StartAddr into the write pointer and Length into the remaining count.
  - Clear WordCount and Checksum; Done=0.
  - If Length==0, go to DONE. Done is high the next cycle, with zero writes.
  - Otherwise go to LOAD.
- LOAD:
  - WordReady=1 and Busy=1 combinationally from the state.
  - Transfer occurs on a rising edge with WordValid&&WordReady. On that edge:
    - Mem[ptr] <= WordIn.
    - ptr <= ptr+1 modulo 2**IW (wraps 2**IW-1 -> 0).
    - WordCount <= WordCount+1.
    - remaining <= remaining-1.
  - WordValid=0: no write; all state is held. The host may stall indefinitely.
  - On the edge that accepts the final word (remaining==1), go to DONE. WordReady=0 from the next cycle, so no extra word is ever accepted.
  - Start in LOAD is ignored; latched StartAddr and Length are unchanged.
- DONE: Done=1, Busy=0, WordReady=0. Stays until an accepted Start or Reset.
- Read port:
  - Fully combinational; no clock latency.
  - A write to address A is visible on InstOut the cycle after its accepting edge.
  - A read of A in the same cycle as its write returns the old data.
- Length=2**IW fills the whole store. Starting at StartAddr≠0 wraps and ends at StartAddr-1.
- Reset mid-LOAD: words already written stay in memory, the remainder of the load is abandoned, and the state is IDLE.
- Initial contents: none required; a bench may $readmemb into the store before use.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - Checksum <= Checksum ^ WordIn on every accepted transfer.
  - Cleared on accepted Start and on Reset.
  - Holds its value in DONE.
- Undefined:
  - The Checksum port still exists and is tied to 0.
  - No XOR logic is synthesized.

Test Plan:
- Basic load: Reset, then Start with StartAddr=0, Length=3. Drive WordValid continuously with 9'h1A5, 9'h0FF, 9'h100.
  - Busy=1 for exactly 3 cycles, then Done=1, WordCount=3.
  - InstOut at addresses 0,1,2 = 1A5, 0FF, 100.
  - Checksum=0x05A when enabled.
- Backpressure: Length=2, with WordValid low for 4 cycles between words.
  - Only 2 writes occur; WordReady stays 1 throughout LOAD; Done rises on the cycle after the 2nd accept.
- Wrap: IW=4 build, StartAddr=14, Length=4, words 1,2,3,4.
  - Mem[14]=1, Mem[15]=2, Mem[0]=3, Mem[1]=4; Mem[2] unchanged.
- Length=0: Start in IDLE.
  - Done=1 one cycle later; no write; WordReady never asserts; WordCount=0.
- Reset mid-load: Length=5, assert Reset asynchronously after 2 accepted words.
  - Immediately Busy=0, WordReady=0, Done=0, WordCount=0.
  - Mem[0..1] hold the written words; Mem[2..4] unchanged.
- Start ignored in LOAD: Length=3 from address 0; pulse Start with StartAddr=8 after the 1st word.
  - Load continues into addresses 1,2; Mem[8] unchanged; WordCount=3.
